// File: rtl/instr_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_imm_encoder
//  Description : Packs RV32 addi/lw/sw/beq words from register fields and a
//                signed immediate into a 2-entry output FIFO with byte address.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_imm_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        fmt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [31:0]       imm_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o
);

  localparam logic [1:0] c_fmt_addi   = 2'd0;
  localparam logic [1:0] c_fmt_lw     = 2'd1;
  localparam logic [1:0] c_fmt_sw     = 2'd2;
  localparam logic [6:0] c_op_imm     = 7'b0010011;
  localparam logic [6:0] c_op_load    = 7'b0000011;
  localparam logic [6:0] c_op_store   = 7'b0100011;
  localparam logic [6:0] c_op_branch  = 7'b1100011;
  localparam logic [2:0] c_f3_word    = 3'b010;
  localparam logic [2:0] c_f3_zero    = 3'b000;
  localparam logic [1:0] c_depth      = 2'd2;
  localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);

  logic [31:0]       r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  logic [31:0]       w_enc;
  logic              w_imm_ok;
  logic              w_full;
  logic              w_empty;
  logic              w_req_fire;
  logic              w_push;
  logic              w_pop;

  // In range exactly when bits 31..11 are a pure sign extension.
  assign w_imm_ok = (&imm_i[31:11]) | ~(|imm_i[31:11]);

  // beq takes a halfword offset, so imm bit n lands where byte-offset bit n+1 lives.
  always_comb begin
    w_enc = '0;
    case (fmt_i)
      c_fmt_addi: w_enc = {imm_i[11:0], rs1_i, c_f3_zero, rd_i, c_op_imm};
      c_fmt_lw:   w_enc = {imm_i[11:0], rs1_i, c_f3_word, rd_i, c_op_load};
      c_fmt_sw:   w_enc = {imm_i[11:5], rs2_i, rs1_i, c_f3_word, imm_i[4:0], c_op_store};
      default:    w_enc = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, c_f3_zero,
                           imm_i[3:0], imm_i[10], c_op_branch};
    endcase
  end

  assign w_full        = (r_count == c_depth);
  assign w_empty       = (r_count == 2'd0);
  assign req_ready_o   = !w_full && !start_i;
  assign w_req_fire    = req_valid_i && req_ready_o;
  assign w_push        = w_req_fire && w_imm_ok;
  assign instr_valid_o = !w_empty;
  assign w_pop         = instr_valid_o && instr_ready_i;

  assign instr_o = instr_valid_o ? r_mem[r_rd_ptr] : 32'd0;
  assign addr_o  = r_addr;
  assign err_o   = r_err;

  // Head address advances on pop; start_i overrides push and pop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_addr   <= '0;
      r_err    <= 1'b0;
    end else if (start_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_addr   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_enc;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_addr   <= r_addr + c_addr_step;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_req_fire && !w_imm_ok) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_imm_encoder.sv
`default_nettype none
// Scoreboard bench for instr_imm_encoder: driver pushes expected words,
// an independent monitor pops and compares whenever a word is consumed.
module tb_instr_imm_encoder;

  localparam int ADDR_W   = 4;
  localparam int ADDR_MOD = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [1:0]        fmt_i = '0;
  logic [4:0]        rd_i = '0;
  logic [4:0]        rs1_i = '0;
  logic [4:0]        rs2_i = '0;
  logic [31:0]       imm_i = '0;
  logic              instr_valid_o;
  logic              instr_ready_i = 1'b0;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] addr_o;
  logic              err_o;

  instr_imm_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .fmt_i         (fmt_i),
    .rd_i          (rd_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .imm_i         (imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .addr_o        (addr_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    int          addr;
    int          imm;
    int          fmt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   exp_next_addr = 0;
  bit   exp_err = 1'b0;
  bit   pend_set = 1'b0;
  bit   pend_clr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ISA-level reference: fields placed per the RV32 I/S/B layouts.
  function automatic logic [31:0] ref_encode(int fmt, int rd, int rs1, int rs2, int imm);
    int off;
    case (fmt)
      0: return 32'(((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h13);
      1: return 32'(((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03);
      2: return 32'((((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) |
                    ((imm & 'h1F) << 7) | 'h23);
      default: begin
        off = imm * 2;
        return 32'((((off >> 12) & 1) << 31) | (((off >> 5) & 'h3F) << 25) | (rs2 << 20) |
                   (rs1 << 15) | (((off >> 1) & 'hF) << 8) | (((off >> 11) & 1) << 7) | 'h63);
      end
    endcase
  endfunction

  // Immediate sign-extender model; beq yields the halfword offset.
  function automatic int ref_decode(logic [31:0] w, int fmt);
    logic [12:0] b;
    case (fmt)
      0, 1: return int'($signed(w[31:20]));
      2:    return int'($signed({w[31:25], w[11:7]}));
      default: begin
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        return int'($signed(b)) / 2;
      end
    endcase
  endfunction

  task automatic cycle(input bit v, input int fmt, input int rd, input int rs1, input int rs2,
                       input int imm, input bit rdy, input bit st,
                       input logic [31:0] exp_word, input bit use_exp, output bit fire);
    exp_t e;
    @(negedge clk);
    if (pend_clr) exp_err = 1'b0;
    else if (pend_set) exp_err = 1'b1;
    pend_clr = 1'b0;
    pend_set = 1'b0;
    req_valid_i   = v;
    fmt_i         = 2'(fmt);
    rd_i          = 5'(rd);
    rs1_i         = 5'(rs1);
    rs2_i         = 5'(rs2);
    imm_i         = 32'(imm);
    instr_ready_i = rdy;
    start_i       = st;
    #1;
    chk("req_ready", 32'(req_ready_o), 32'(sb.size() < 2 && !st));
    chk("instr_valid", 32'(instr_valid_o), 32'(sb.size() != 0));
    if (sb.size() != 0) chk("addr_head", 32'(addr_o), 32'(sb[0].addr));
    else                chk("addr_idle", 32'(addr_o), 32'(exp_next_addr));
    fire = v && req_ready_o;
    if (st) begin
      sb.delete();
      exp_next_addr = 0;
      pend_clr = 1'b1;
    end else if (fire) begin
      if (imm >= -2048 && imm <= 2047) begin
        e.instr = use_exp ? exp_word : ref_encode(fmt, rd, rs1, rs2, imm);
        e.addr  = exp_next_addr;
        e.imm   = imm;
        e.fmt   = fmt;
        sb.push_back(e);
        exp_next_addr = (exp_next_addr + 4) % ADDR_MOD;
      end else begin
        pend_set = 1'b1;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    bit f;
    cycle(1'b0, 0, 0, 0, 0, 0, rdy, 1'b0, 32'd0, 1'b0, f);
  endtask

  task automatic do_start(input bit rdy);
    bit f;
    cycle(1'b1, 0, 1, 1, 1, 1, rdy, 1'b1, 32'd0, 1'b0, f);
  endtask

  task automatic send(input int fmt, input int rd, input int rs1, input int rs2, input int imm,
                      input bit rdy, input logic [31:0] exp_word, input bit use_exp);
    bit f;
    cycle(1'b1, fmt, rd, rs1, rs2, imm, rdy, 1'b0, exp_word, use_exp, f);
  endtask

  task automatic send_wait(input int fmt, input int rd, input int rs1, input int rs2,
                           input int imm, input bit rdy);
    bit f;
    f = 1'b0;
    for (int t = 0; t < 10 && !f; t++) begin
      cycle(1'b1, fmt, rd, rs1, rs2, imm, rdy, 1'b0, 32'd0, 1'b0, f);
    end
    checks++;
    if (!f) begin
      failures++;
      $display("FAIL accept_timeout: got no handshake expected handshake within 10 cycles");
    end
  endtask

  // Monitor: compares consumed words and the hold/err behaviour.
  bit                hold_prev = 1'b0;
  logic [31:0]       prev_instr = '0;
  logic [ADDR_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    #2;
    if (!rst_i) begin
      hold_prev = 1'b0;
    end else begin
      chk("err", 32'(err_o), 32'(exp_err));
      if (hold_prev) begin
        chk("hold_valid", 32'(instr_valid_o), 32'd1);
        chk("hold_instr", instr_o, prev_instr);
        chk("hold_addr", 32'(addr_o), 32'(prev_addr));
      end
      if (instr_valid_o && instr_ready_i && !start_i) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_empty: got word %h expected no word", instr_o);
        end else begin
          mon_e = sb.pop_front();
          chk("instr", instr_o, mon_e.instr);
          chk("addr", 32'(addr_o), 32'(mon_e.addr));
          chk("decode_imm", 32'(ref_decode(instr_o, mon_e.fmt)), 32'(mon_e.imm));
        end
      end
      hold_prev  = instr_valid_o && !instr_ready_i && !start_i;
      prev_instr = instr_o;
      prev_addr  = addr_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int imm;
    bit f;
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b1;

    // addi x5, x0, -1
    send(0, 5, 0, 0, -1, 1'b1, 32'hFFF00293, 1'b1);
    repeat (2) idle(1'b1);

    // lw then sw from a fresh address base
    do_start(1'b1);
    send(1, 3, 2, 0, -4, 1'b1, 32'hFFC12183, 1'b1);
    send(2, 0, 1, 2, 8, 1'b1, 32'h0020A423, 1'b1);
    repeat (3) idle(1'b1);

    // beq, including the most negative offset
    do_start(1'b1);
    send(3, 0, 1, 2, 4, 1'b1, 32'h00208463, 1'b1);
    send(3, 0, 3, 4, -2048, 1'b1, 32'h0, 1'b0);
    send(3, 0, 5, 6, 2047, 1'b1, 32'h0, 1'b0);
    repeat (3) idle(1'b1);

    // out-of-range immediate: consumed, not enqueued, sticky error
    send(0, 1, 1, 0, 2048, 1'b1, 32'h0, 1'b0);
    repeat (3) idle(1'b1);
    do_start(1'b1);
    repeat (2) idle(1'b1);

    // back-pressure: third request refused while full, head held
    send(0, 1, 2, 0, 100, 1'b0, 32'h0, 1'b0);
    send(1, 2, 3, 0, -100, 1'b0, 32'h0, 1'b0);
    send(2, 0, 4, 5, 7, 1'b0, 32'h0, 1'b0);
    repeat (2) idle(1'b0);
    send_wait(2, 0, 4, 5, 7, 1'b1);
    repeat (4) idle(1'b1);

    // address wrap over five pops, then start with a full buffer
    do_start(1'b1);
    for (int i = 0; i < 5; i++) send(0, i, i, 0, i * 3, 1'b1, 32'h0, 1'b0);
    repeat (3) idle(1'b1);
    send(0, 1, 1, 0, 1, 1'b0, 32'h0, 1'b0);
    send(0, 2, 2, 0, 2, 1'b0, 32'h0, 1'b0);
    do_start(1'b0);
    repeat (2) idle(1'b1);

    // asynchronous reset mid-transfer
    send(0, 1, 1, 0, 11, 1'b0, 32'h0, 1'b0);
    send(0, 2, 2, 0, 22, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #3;
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    chk("arst_addr", 32'(addr_o), 32'd0);
    sb.delete();
    exp_next_addr = 0;
    exp_err  = 1'b0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0: imm = -2048;
        1: imm = 2047;
        2: imm = ($urandom_range(0, 7) == 0) ? -2049 : 5;
        3: imm = ($urandom_range(0, 7) == 0) ? 2048 : -5;
        4: imm = ($urandom_range(0, 3) == 0) ? int'($urandom) : 0;
        default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, 32'h0, 1'b0, f);
    end

    repeat (4) idle(1'b1);
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
